// File: rtl/inst_fetch_interface.sv
// Miss-side fetch engine: turns an icache miss into one sram-like bus read and returns word+address for the fill.
// Latency: enable -> choke low in 3 cycles minimum (IDLE, REQ, WAIT, DONE); longer when addr_ok/data_ok are late.
// Backpressure: inst_req/inst_addr held stable until inst_addr_ok; stall held until data is ready. IF_TIMEOUT_EN adds a WAIT watchdog.
module inst_fetch_interface #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        interface_enable,
  input  logic [31:0] interface_PC,
  output logic [31:0] this_time_pc,
  output logic [31:0] interface_instruction,
  output logic        cache_wait_stop_choke,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  output logic        bus_timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Watchdog fires on the last of TIMEOUT_CYCLES WAIT cycles (counter value TIMEOUT_CYCLES-1).
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] CNT_ONE      = TIMEOUT_W'(1);

  state_t      state, state_n;
  logic [31:0] req_pc;
  logic        discard;
  logic        redirect;
  logic        latch_req;
  logic        capture;
  logic        clr_discard;
  logic        timeout_hit;

  // The cache has moved on (new PC or hit) while our read is still in flight on the bus.
  assign redirect = ((state == S_REQ) || (state == S_WAIT)) &&
                    (!interface_enable || (interface_PC != req_pc));

  // Stall only a live miss; released in DONE once the returned address matches what the cache wants.
  assign cache_wait_stop_choke = interface_enable &&
                                 !((state == S_DONE) && (this_time_pc == interface_PC));

`ifdef IF_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 timeout_flag;

  assign timeout_hit = (state == S_WAIT) && !inst_data_ok && (wait_cnt == TIMEOUT_LAST);
  assign bus_timeout = timeout_flag;

  // Count WAIT cycles (zero whenever outside WAIT, so each entry starts fresh); timeout flag is sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state != S_WAIT) begin
        wait_cnt <= '0;
      end else if (!inst_data_ok) begin
        wait_cnt <= wait_cnt + CNT_ONE;
      end
      if (timeout_hit) begin
        timeout_flag <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign bus_timeout        = 1'b0;
  assign unused_timeout_cfg = ^{TIMEOUT_LAST, CNT_ONE};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state, bus request outputs and datapath strobes.
  always_comb begin
    state_n     = state;
    inst_req    = 1'b0;
    inst_addr   = 32'h0;
    latch_req   = 1'b0;
    capture     = 1'b0;
    clr_discard = 1'b0;
    case (state)
      S_IDLE: begin
        if (interface_enable) begin
          latch_req = 1'b1;
          state_n   = S_REQ;
        end
      end
      S_REQ: begin
        inst_req  = 1'b1;
        inst_addr = req_pc;
        if (inst_addr_ok) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          // A redirect seen in the data_ok cycle itself also drops the word.
          if (discard || redirect) begin
            clr_discard = 1'b1;
            state_n     = S_IDLE;
          end else begin
            capture = 1'b1;
            state_n = S_DONE;
          end
        end else if (timeout_hit) begin
          state_n = S_IDLE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Request address, fill result and discard bookkeeping.
  // After a timeout discard stays set so the abandoned read's late data_ok, if it lands in the
  // reissued fetch's WAIT, is the one that gets dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_pc                <= 32'h0;
      this_time_pc          <= 32'h0;
      interface_instruction <= 32'h0;
      discard               <= 1'b0;
    end else begin
      if (latch_req) begin
        req_pc <= interface_PC;
      end
      if (capture) begin
        this_time_pc          <= req_pc;
        interface_instruction <= inst_rdata;
      end
      if (clr_discard) begin
        discard <= 1'b0;
      end else if (redirect || timeout_hit) begin
        discard <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_interface.sv
// Directed bench for inst_fetch_interface: inputs change 1ns after the rising edge,
// outputs are sampled 1ns later, inside the same cycle.
// Define IF_TIMEOUT_EN for the build to also exercise the bus watchdog (TIMEOUT_CYCLES=4).
module tb_inst_fetch_interface;

  logic        clk;
  logic        reset;
  logic        interface_enable;
  logic [31:0] interface_PC;
  logic [31:0] this_time_pc;
  logic [31:0] interface_instruction;
  logic        cache_wait_stop_choke;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        bus_timeout;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef IF_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  inst_fetch_interface #(
    .TIMEOUT_CYCLES(TB_TIMEOUT),
    .TIMEOUT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .interface_enable(interface_enable),
    .interface_PC(interface_PC),
    .this_time_pc(this_time_pc),
    .interface_instruction(interface_instruction),
    .cache_wait_stop_choke(cache_wait_stop_choke),
    .inst_req(inst_req),
    .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_rdata(inst_rdata),
    .inst_data_ok(inst_data_ok),
    .bus_timeout(bus_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    interface_enable = 1'b0;
    interface_PC     = 32'h0;
    inst_addr_ok     = 1'b0;
    inst_data_ok     = 1'b0;
    inst_rdata       = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", inst_req); end
    n_checks++; if (inst_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 00000000", inst_addr); end
    n_checks++; if (this_time_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 00000000", this_time_pc); end
    n_checks++; if (interface_instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 00000000", interface_instruction); end
    n_checks++; if (cache_wait_stop_choke !== 1'b0) begin n_fail++; $display("FAIL reset_choke: got %b expected 0", cache_wait_stop_choke); end
    n_checks++; if (bus_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", bus_timeout); end
    tick();
  endtask

  task automatic test_basic_miss();
    // cycle 0: miss presented, still IDLE
    interface_enable = 1'b1; interface_PC = 32'hBFC00000;
    #1;
    n_checks++; if (cache_wait_stop_choke !== 1'b1) begin n_fail++; $display("FAIL basic_choke_c0: got %b expected 1", cache_wait_stop_choke); end
    n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_c0: got %b expected 0", inst_req); end
    tick();
    // cycle 1: REQ, bus accepts at once
    inst_addr_ok = 1'b1;
    #1;
    n_checks++; if (inst_req !== 1'b1) begin n_fail++; $display("FAIL basic_req_c1: got %b expected 1", inst_req); end
    n_checks++; if (inst_addr !== 32'hBFC00000) begin n_fail++; $display("FAIL basic_addr_c1: got %h expected bfc00000", inst_addr); end
    n_checks++; if (cache_wait_stop_choke !== 1'b1) begin n_fail++; $display("FAIL basic_choke_c1: got %b expected 1", cache_wait_stop_choke); end
    tick();
    // cycle 2: WAIT, data returns
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3C1D0001;
    #1;
    n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_c2: got %b expected 0", inst_req); end
    n_checks++; if (cache_wait_stop_choke !== 1'b1) begin n_fail++; $display("FAIL basic_choke_c2: got %b expected 1", cache_wait_stop_choke); end
    tick();
    // cycle 3: DONE, stall released
    inst_data_ok = 1'b0; inst_rdata = 32'h0;
    #1;
    n_checks++; if (cache_wait_stop_choke !== 1'b0) begin n_fail++; $display("FAIL basic_choke_c3: got %b expected 0", cache_wait_stop_choke); end
    n_checks++; if (this_time_pc !== 32'hBFC00000) begin n_fail++; $display("FAIL basic_pc: got %h expected bfc00000", this_time_pc); end
    n_checks++; if (interface_instruction !== 32'h3C1D0001) begin n_fail++; $display("FAIL basic_instr: got %h expected 3c1d0001", interface_instruction); end
    tick();
    // cycle 4: cache hits, drops enable
    interface_enable = 1'b0;
    #1;
    n_checks++; if (cache_wait_stop_choke !== 1'b0) begin n_fail++; $display("FAIL basic_choke_c4: got %b expected 0", cache_wait_stop_choke); end
    n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_c4: got %b expected 0", inst_req); end
    tick();
  endtask

  task automatic test_slow_bus();
    interface_enable = 1'b1; interface_PC = 32'h00400000;
    tick();
    // cycles 1..4 in REQ; addr_ok only on the fourth
    for (int i = 0; i < 4; i++) begin
      inst_addr_ok = (i == 3);
      #1;
      n_checks++; if (inst_req !== 1'b1) begin n_fail++; $display("FAIL slow_req_%0d: got %b expected 1", i, inst_req); end
      n_checks++; if (inst_addr !== 32'h00400000) begin n_fail++; $display("FAIL slow_addr_%0d: got %h expected 00400000", i, inst_addr); end
      n_checks++; if (cache_wait_stop_choke !== 1'b1) begin n_fail++; $display("FAIL slow_choke_req_%0d: got %b expected 1", i, cache_wait_stop_choke); end
      tick();
    end
    inst_addr_ok = 1'b0;
    // five WAIT cycles, data on the fifth
    for (int i = 0; i < 5; i++) begin
      inst_data_ok = (i == 4);
      inst_rdata   = (i == 4) ? 32'h12345678 : 32'hFFFF0000;
      #1;
      n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL slow_wait_req_%0d: got %b expected 0", i, inst_req); end
      n_checks++; if (cache_wait_stop_choke !== 1'b1) begin n_fail++; $display("FAIL slow_choke_wait_%0d: got %b expected 1", i, cache_wait_stop_choke); end
      n_checks++; if (this_time_pc !== 32'hBFC00000) begin n_fail++; $display("FAIL slow_pc_hold_%0d: got %h expected bfc00000", i, this_time_pc); end
      tick();
    end
    inst_data_ok = 1'b0;
    #1;
    n_checks++; if (cache_wait_stop_choke !== 1'b0) begin n_fail++; $display("FAIL slow_choke_done: got %b expected 0", cache_wait_stop_choke); end
    n_checks++; if (this_time_pc !== 32'h00400000) begin n_fail++; $display("FAIL slow_pc: got %h expected 00400000", this_time_pc); end
    n_checks++; if (interface_instruction !== 32'h12345678) begin n_fail++; $display("FAIL slow_instr: got %h expected 12345678", interface_instruction); end
    tick();
    interface_enable = 1'b0;
    tick();
  endtask

  task automatic test_redirect();
    interface_enable = 1'b1; interface_PC = 32'h00000100;
    tick();
    inst_addr_ok = 1'b1;             // REQ
    tick();
    inst_addr_ok = 1'b0;             // WAIT: cache redirects
    interface_PC = 32'h00000200;
    #1;
    n_checks++; if (cache_wait_stop_choke !== 1'b1) begin n_fail++; $display("FAIL redir_choke_wait: got %b expected 1", cache_wait_stop_choke); end
    tick();
    inst_data_ok = 1'b1; inst_rdata = 32'hAAAAAAAA;   // stale data
    tick();
    inst_data_ok = 1'b0; inst_rdata = 32'h0;          // back in IDLE
    #1;
    n_checks++; if (this_time_pc !== 32'h00400000) begin n_fail++; $display("FAIL redir_pc_kept: got %h expected 00400000", this_time_pc); end
    n_checks++; if (interface_instruction !== 32'h12345678) begin n_fail++; $display("FAIL redir_instr_kept: got %h expected 12345678", interface_instruction); end
    n_checks++; if (cache_wait_stop_choke !== 1'b1) begin n_fail++; $display("FAIL redir_choke_idle: got %b expected 1", cache_wait_stop_choke); end
    n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL redir_req_idle: got %b expected 0", inst_req); end
    tick();
    inst_addr_ok = 1'b1;             // REQ for the new PC
    #1;
    n_checks++; if (inst_addr !== 32'h00000200) begin n_fail++; $display("FAIL redir_addr2: got %h expected 00000200", inst_addr); end
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h55AA1234;
    tick();
    inst_data_ok = 1'b0; inst_rdata = 32'h0;
    #1;
    n_checks++; if (cache_wait_stop_choke !== 1'b0) begin n_fail++; $display("FAIL redir_choke_done: got %b expected 0", cache_wait_stop_choke); end
    n_checks++; if (this_time_pc !== 32'h00000200) begin n_fail++; $display("FAIL redir_pc2: got %h expected 00000200", this_time_pc); end
    n_checks++; if (interface_instruction !== 32'h55AA1234) begin n_fail++; $display("FAIL redir_instr2: got %h expected 55aa1234", interface_instruction); end
    tick();
    interface_enable = 1'b0;
    tick();
  endtask

  task automatic test_hit_passthrough();
    for (int i = 0; i < 10; i++) begin
      interface_enable = 1'b0;
      interface_PC     = 32'h00001000 + 32'(i * 4);
      inst_data_ok     = i[0];
      inst_addr_ok     = i[1];
      inst_rdata       = 32'hC0DE0000 + 32'(i);
      #1;
      n_checks++; if (cache_wait_stop_choke !== 1'b0) begin n_fail++; $display("FAIL hit_choke_%0d: got %b expected 0", i, cache_wait_stop_choke); end
      n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL hit_req_%0d: got %b expected 0", i, inst_req); end
      tick();
    end
    idle_inputs();
    #1;
    n_checks++; if (this_time_pc !== 32'h00000200) begin n_fail++; $display("FAIL hit_pc_kept: got %h expected 00000200", this_time_pc); end
    n_checks++; if (interface_instruction !== 32'h55AA1234) begin n_fail++; $display("FAIL hit_instr_kept: got %h expected 55aa1234", interface_instruction); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    interface_enable = 1'b1; interface_PC = 32'h00000300;
    tick();
    inst_addr_ok = 1'b1;             // REQ
    tick();
    inst_addr_ok = 1'b0;             // WAIT, reset for one cycle
    reset = 1'b1;
    tick();
    reset = 1'b0;                    // IDLE; late data arrives
    interface_enable = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'hDEADBEEF;
    #1;
    n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL rstw_req: got %b expected 0", inst_req); end
    n_checks++; if (inst_addr !== 32'h0) begin n_fail++; $display("FAIL rstw_addr: got %h expected 00000000", inst_addr); end
    n_checks++; if (this_time_pc !== 32'h0) begin n_fail++; $display("FAIL rstw_pc: got %h expected 00000000", this_time_pc); end
    n_checks++; if (interface_instruction !== 32'h0) begin n_fail++; $display("FAIL rstw_instr: got %h expected 00000000", interface_instruction); end
    n_checks++; if (cache_wait_stop_choke !== 1'b0) begin n_fail++; $display("FAIL rstw_choke: got %b expected 0", cache_wait_stop_choke); end
    tick();
    inst_data_ok = 1'b0; inst_rdata = 32'h0;
    #1;
    n_checks++; if (interface_instruction !== 32'h0) begin n_fail++; $display("FAIL rstw_instr_after: got %h expected 00000000", interface_instruction); end
    n_checks++; if (this_time_pc !== 32'h0) begin n_fail++; $display("FAIL rstw_pc_after: got %h expected 00000000", this_time_pc); end
    tick();
  endtask

  task automatic test_back_to_back();
    // miss A at minimum latency, then miss B presented in the cycle after DONE
    interface_enable = 1'b1; interface_PC = 32'h00001000;
    tick();
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h11111111;
    tick();
    inst_data_ok = 1'b0;
    #1;
    n_checks++; if (cache_wait_stop_choke !== 1'b0) begin n_fail++; $display("FAIL b2b_choke_doneA: got %b expected 0", cache_wait_stop_choke); end
    tick();
    interface_PC = 32'h00002000;     // IDLE: new miss
    #1;
    n_checks++; if (cache_wait_stop_choke !== 1'b1) begin n_fail++; $display("FAIL b2b_choke_idleB: got %b expected 1", cache_wait_stop_choke); end
    tick();
    inst_addr_ok = 1'b1;
    #1;
    n_checks++; if (inst_addr !== 32'h00002000) begin n_fail++; $display("FAIL b2b_addrB: got %h expected 00002000", inst_addr); end
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h22222222;
    tick();
    inst_data_ok = 1'b0;
    #1;
    n_checks++; if (cache_wait_stop_choke !== 1'b0) begin n_fail++; $display("FAIL b2b_choke_doneB: got %b expected 0", cache_wait_stop_choke); end
    n_checks++; if (interface_instruction !== 32'h22222222) begin n_fail++; $display("FAIL b2b_instrB: got %h expected 22222222", interface_instruction); end
    tick();
    idle_inputs();
    tick();
  endtask

`ifdef IF_TIMEOUT_EN
  task automatic test_timeout();
    interface_enable = 1'b1; interface_PC = 32'h00000500;
    tick();
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (bus_timeout !== 1'b0) begin n_fail++; $display("FAIL to_flag_early_%0d: got %b expected 0", i, bus_timeout); end
      tick();
    end
    #1;                              // IDLE after abort
    n_checks++; if (bus_timeout !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b expected 1", bus_timeout); end
    n_checks++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL to_req_idle: got %b expected 0", inst_req); end
    tick();
    #1;                              // reissued request
    n_checks++; if (inst_req !== 1'b1) begin n_fail++; $display("FAIL to_reissue_req: got %b expected 1", inst_req); end
    n_checks++; if (inst_addr !== 32'h00000500) begin n_fail++; $display("FAIL to_reissue_addr: got %h expected 00000500", inst_addr); end
    tick();
    idle_inputs();
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    #1;
    n_checks++; if (bus_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b expected 1", bus_timeout); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_miss();
    test_slow_bus();
    test_redirect();
    test_hit_passthrough();
    test_reset_mid_wait();
    test_back_to_back();
`ifdef IF_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
